// File: rtl/simmem_release_scheduler.sv
// simmem_release_scheduler: per-ID pending/delay tracking with round-robin release grants (SIMMEM_RELEASE_STATS_EN adds rel_count_o and checks)
module simmem_release_scheduler #(
  parameter int IDWidth    = 2,
  parameter int DelayWidth = 8,
  parameter int CntWidth   = 4
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic [DelayWidth-1:0]   cfg_delay_i,
  input  logic                    enq_valid_i,
  input  logic [IDWidth-1:0]      enq_id_i,
  output logic                    enq_ready_o,
  output logic                    rel_valid_o,
  output logic [IDWidth-1:0]      rel_id_o,
  output logic [(2**IDWidth)-1:0] rel_onehot_o,
  input  logic                    rel_ready_i,
  output logic                    busy_o
`ifdef SIMMEM_RELEASE_STATS_EN
  , output logic [31:0]           rel_count_o
`endif
);
  localparam int NumIds = 2**IDWidth;
  localparam logic [CntWidth-1:0] CntMax = '1;

  logic [CntWidth-1:0]   pending_q [NumIds];
  logic [CntWidth-1:0]   pending_d [NumIds];
  logic [DelayWidth-1:0] timer_q [NumIds];
  logic [DelayWidth-1:0] timer_d [NumIds];
  logic [IDWidth-1:0]    rr_ptr_q, rr_ptr_d, lock_id_q, lock_id_d, gnt_id;
  logic                  lock_q, lock_d, gnt_found, rel_fire, enq_fire;
  logic [NumIds-1:0]     eligible, nonzero, inc, dec;

  // An ID is eligible once it holds responses and its delay has run out
  always_comb begin
    for (int i = 0; i < NumIds; i++) begin
      nonzero[i]  = pending_q[i] != '0;
      eligible[i] = nonzero[i] && (timer_q[i] == '0);
    end
  end

  // Round-robin search for the first eligible ID starting at rr_ptr
  always_comb begin
    gnt_id    = '0;
    gnt_found = 1'b0;
    for (int k = 0; k < NumIds; k++) begin
      if (!gnt_found && eligible[rr_ptr_q + IDWidth'(k)]) begin
        gnt_id    = rr_ptr_q + IDWidth'(k);
        gnt_found = 1'b1;
      end
    end
  end

  assign busy_o       = |nonzero;
  assign rel_valid_o  = lock_q || gnt_found;
  assign rel_id_o     = lock_q ? lock_id_q : gnt_id;
  assign rel_onehot_o = rel_valid_o ? NumIds'(1) << rel_id_o : '0;
  assign rel_fire     = rel_valid_o && rel_ready_i;
  assign enq_ready_o  = (pending_q[enq_id_i] != CntMax) || (rel_fire && (rel_id_o == enq_id_i));
  assign enq_fire     = enq_valid_i && enq_ready_o;

  // Counter/timer updates; a timer reloads when an ID becomes non-empty or stays non-empty after a release
  always_comb begin
    for (int i = 0; i < NumIds; i++) begin
      inc[i]       = enq_fire && (enq_id_i == IDWidth'(i));
      dec[i]       = rel_fire && (rel_id_o == IDWidth'(i));
      pending_d[i] = pending_q[i] + CntWidth'(inc[i]) - CntWidth'(dec[i]);
      timer_d[i]   = ((inc[i] && !nonzero[i]) || (dec[i] && pending_d[i] != '0)) ? cfg_delay_i
                   : timer_q[i] - DelayWidth'(timer_q[i] != '0);
    end
    rr_ptr_d  = rel_fire ? rel_id_o + IDWidth'(1) : rr_ptr_q;
    lock_d    = rel_valid_o && !rel_ready_i;
    lock_id_d = rel_id_o;
  end

  // State registers
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < NumIds; i++) begin
        pending_q[i] <= '0;
        timer_q[i]   <= '0;
      end
      rr_ptr_q  <= '0;
      lock_q    <= 1'b0;
      lock_id_q <= '0;
    end else begin
      pending_q <= pending_d;
      timer_q   <= timer_d;
      rr_ptr_q  <= rr_ptr_d;
      lock_q    <= lock_d;
      lock_id_q <= lock_id_d;
    end
  end

`ifdef SIMMEM_RELEASE_STATS_EN
  logic [31:0]        rel_count_q, rel_count_d;
  logic               hold_q, hold_d;
  logic [IDWidth-1:0] hold_id_q, hold_id_d;

  // Release counter plus the previous-cycle stall used by the stability check
  always_comb begin
    rel_count_d = rel_count_q + 32'(rel_fire);
    hold_d      = rel_valid_o && !rel_ready_i;
    hold_id_d   = rel_id_o;
  end

  // Statistics registers
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rel_count_q <= '0;
      hold_q      <= 1'b0;
      hold_id_q   <= '0;
    end else begin
      rel_count_q <= rel_count_d;
      hold_q      <= hold_d;
      hold_id_q   <= hold_id_d;
    end
  end

  assign rel_count_o = rel_count_q;

  // Protocol checks on the release side
  always @(posedge clk_i) begin
    if (rst_ni) begin
      assert (!rel_fire || nonzero[rel_id_o]) else $error("release of empty ID");
      assert (!hold_q || (rel_valid_o && rel_id_o == hold_id_q)) else $error("grant changed while stalled");
      assert ($onehot0(rel_onehot_o)) else $error("release enable not one-hot");
    end
  end
`endif

endmodule

// File: tb/tb_simmem_release_scheduler.sv
// tb_simmem_release_scheduler: directed stimulus checked every cycle against a timestamp-based model
module tb_simmem_release_scheduler;
  logic       clk = 1'b0, rst_ni = 1'b0;
  logic [7:0] cfg_delay = '0;
  logic       enq_valid = 1'b0, rel_ready = 1'b0;
  logic [1:0] enq_id = '0;
  logic       enq_ready, rel_valid, busy;
  logic [1:0] rel_id;
  logic [3:0] rel_onehot;

  simmem_release_scheduler dut (
    .clk_i(clk), .rst_ni(rst_ni), .cfg_delay_i(cfg_delay),
    .enq_valid_i(enq_valid), .enq_id_i(enq_id), .enq_ready_o(enq_ready),
    .rel_valid_o(rel_valid), .rel_id_o(rel_id), .rel_onehot_o(rel_onehot),
    .rel_ready_i(rel_ready), .busy_o(busy)
  );

  always #5 clk = ~clk;

  int total = 0, bad = 0;

  task automatic chk(input string nm, input int got, input int want);
    total++;
    if (got != want) begin
      bad++;
      $display("FAIL %s got=%0d want=%0d at %0t", nm, got, want, $time);
    end
  endtask

  function automatic int gid();
    return rel_valid ? int'(rel_id) : -1;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Model: per ID a response count and the absolute cycle from which it may be released
  int cnt[4], eat[4];
  int rr = 0, held = 0, held_id = 0, cyc = 0, m_valid, m_id, fire, efire, j;

  always @(negedge clk) begin
    if (!rst_ni) begin
      for (int i = 0; i < 4; i++) begin
        cnt[i] = 0;
        eat[i] = 0;
      end
      rr = 0; held = 0; held_id = 0;
      chk("rst_valid", rel_valid, 0);
      chk("rst_onehot", rel_onehot, 0);
      chk("rst_id", rel_id, 0);
      chk("rst_enq_ready", enq_ready, 1);
      chk("rst_busy", busy, 0);
    end else begin
      m_valid = 0;
      m_id = 0;
      if (held != 0) begin
        m_valid = 1;
        m_id = held_id;
      end else begin
        for (int k = 0; k < 4; k++) begin
          j = (rr + k) % 4;
          if (m_valid == 0 && cnt[j] > 0 && cyc >= eat[j]) begin
            m_valid = 1;
            m_id = j;
          end
        end
      end
      fire  = (m_valid != 0 && rel_ready) ? 1 : 0;
      efire = (enq_valid && (cnt[enq_id] < 15 || (fire != 0 && m_id == int'(enq_id)))) ? 1 : 0;
      chk("cmp_valid", rel_valid, m_valid);
      if (m_valid != 0) chk("cmp_id", rel_id, m_id);
      chk("cmp_onehot", rel_onehot, m_valid != 0 ? (1 << m_id) : 0);
      chk("cmp_enq_ready", enq_ready, (cnt[enq_id] < 15 || (fire != 0 && m_id == int'(enq_id))) ? 1 : 0);
      chk("cmp_busy", busy, (cnt[0] + cnt[1] + cnt[2] + cnt[3]) > 0 ? 1 : 0);
      if (efire != 0) begin
        if (cnt[enq_id] == 0) eat[enq_id] = cyc + 1 + int'(cfg_delay);
        cnt[enq_id]++;
      end
      if (fire != 0) begin
        cnt[m_id]--;
        if (cnt[m_id] > 0) eat[m_id] = cyc + 1 + int'(cfg_delay);
        rr = (m_id + 1) % 4;
      end
      held = (m_valid != 0 && fire == 0) ? 1 : 0;
      held_id = m_id;
    end
    cyc++;
  end

  int first, g_id, g_oh, vcount, n;
  int exp_pair[5] = '{-1, -1, 0, 1, -1};
  int rel_at[$];

  initial begin
    repeat (3) tick();
    rst_ni = 1'b1;
    repeat (10) tick();
    chk("idle_valid", rel_valid, 0);
    chk("idle_busy", busy, 0);
    chk("idle_enq_ready", enq_ready, 1);

    // single enqueue with delay 5 on ID 2
    cfg_delay = 8'd5; rel_ready = 1'b1; enq_valid = 1'b1; enq_id = 2'd2;
    tick();
    enq_valid = 1'b0;
    first = -1; vcount = 0; g_id = -1; g_oh = -1;
    for (int k = 1; k <= 8; k++) begin
      if (rel_valid) begin
        vcount++;
        if (first < 0) begin
          first = k; g_id = rel_id; g_oh = rel_onehot;
        end
      end
      tick();
    end
    chk("d5_rise_cycle", first, 6);
    chk("d5_id", g_id, 2);
    chk("d5_onehot", g_oh, 4);
    chk("d5_width", vcount, 1);
    chk("d5_busy_after", busy, 0);

    // zero delay, IDs 0,1,3 then a simultaneous pair on 0 and 1
    cfg_delay = 8'd0; enq_valid = 1'b1; enq_id = 2'd0;
    tick();
    chk("rr_g1", gid(), 0);
    enq_id = 2'd1;
    tick();
    chk("rr_g2", gid(), 1);
    enq_id = 2'd3;
    tick();
    chk("rr_g3", gid(), 3);
    enq_valid = 1'b0;
    tick();
    chk("rr_idle", gid(), -1);
    cfg_delay = 8'd3; enq_valid = 1'b1; enq_id = 2'd1;
    tick();
    cfg_delay = 8'd2; enq_id = 2'd0;
    tick();
    enq_valid = 1'b0;
    for (int k = 0; k < 5; k++) begin
      chk("rr_pair", gid(), exp_pair[k]);
      tick();
    end

    // stalled grant on ID 1 while ID 0 becomes eligible; rr_ptr is 2 here
    cfg_delay = 8'd0; rel_ready = 1'b0; enq_valid = 1'b1; enq_id = 2'd1;
    tick();
    chk("hold_id", gid(), 1);
    enq_id = 2'd0;
    tick();
    enq_valid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      chk("hold_id", gid(), 1);
      tick();
    end
    rel_ready = 1'b1;
    chk("hold_fire_id", gid(), 1);
    tick();
    chk("after_hold_id", gid(), 0);
    tick();
    chk("after_hold_idle", gid(), -1);

    // saturation of ID 0 with the longest delay
    cfg_delay = 8'd255; enq_valid = 1'b1; enq_id = 2'd0;
    repeat (15) tick();
    chk("sat_ready_id0", enq_ready, 0);
    enq_id = 2'd1;
    #1;
    chk("sat_ready_id1", enq_ready, 1);
    enq_id = 2'd0;
    tick();
    enq_valid = 1'b0;
    n = 16;
    while (busy && n < 4200) begin
      if (rel_valid && rel_ready) rel_at.push_back(n);
      tick();
      n++;
    end
    chk("sat_releases", rel_at.size(), 15);
    if (rel_at.size() > 0) chk("sat_first", rel_at[0], 256);
    for (int k = 1; k < rel_at.size(); k++) chk("sat_spacing", rel_at[k] - rel_at[k-1], 256);
    chk("sat_drain_busy", busy, 0);

    // asynchronous reset while a grant is stalled
    cfg_delay = 8'd0; rel_ready = 1'b0; enq_valid = 1'b1; enq_id = 2'd2;
    tick();
    enq_valid = 1'b0;
    tick();
    chk("lock_before_rst", gid(), 2);
    rst_ni = 1'b0;
    #1;
    chk("arst_valid", rel_valid, 0);
    chk("arst_onehot", rel_onehot, 0);
    chk("arst_id", rel_id, 0);
    chk("arst_enq_ready", enq_ready, 1);
    chk("arst_busy", busy, 0);
    tick();
    tick();
    rst_ni = 1'b1; rel_ready = 1'b1;
    vcount = 0;
    for (int k = 0; k < 10; k++) begin
      if (rel_valid) vcount++;
      tick();
    end
    chk("post_rst_releases", vcount, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
